pwm_decoder: RTL

- Receive-side counterpart of pwm_generator.
- Samples a single PWM serial line, measures high time and period, and recovers the BIT_W-bit colour value that produced it.
- Used for loop-back checking of the LED display PWM path and as a capture block for board-level self-test.
- Produces one colour sample per PWM period, plus a timeout path for the constant-level codes 0 and max.

---
 rtl/pwm_decoder_pkg.sv | 23 ++
 rtl/pwm_decoder_div.sv | 62 ++++++
 rtl/pwm_decoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/pwm_decoder_pkg.sv
// pwm_decoder_pkg: shared types and sizing helpers for the PWM decoder.
// No ports; imported by pwm_decoder and pwm_decoder_div.
package pwm_decoder_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } pwm_dec_state_t;

  // Clock cycles in one nominal PWM period (integer division).
  function automatic int pwm_period_cyc(
    input int sys_clk,
    input int pwm_freq
  );
    return sys_clk / pwm_freq;
  endfunction

  // Counter width able to hold the timeout count of two periods.
  function automatic int pwm_cnt_w(input int period_cyc);
    return $clog2(2 * period_cyc + 1);
  endfunction

endpackage

// File: rtl/pwm_decoder_div.sv
// pwm_decoder_div: restoring MSB-first divider, one quotient bit per cycle.
// Ports: clk_in, reset_in, start, num, den -> busy, done (pulse), quotient.
module pwm_decoder_div #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 14,
  parameter int BIT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [BIT_W-1:0] quotient
);

  localparam int IDX_W = (BIT_W > 1) ? $clog2(BIT_W) : 1;

  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] den_r;
  logic [NUM_W-1:0] trial;
  logic [IDX_W-1:0] idx;
  logic             fits;

  always_comb begin
    trial = den_r << idx;
    fits  = (rem >= trial);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      den_r    <= '0;
      idx      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          rem      <= num;
          den_r    <= NUM_W'(den);
          idx      <= IDX_W'(BIT_W - 1);
          quotient <= '0;
        end
      end else begin
        quotient[idx] <= fits;
        if (fits) rem <= rem - trial;
        if (idx == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures PWM high time / period and recovers the colour code.
// Ports: clk_in, reset_in, pwm_in -> colour_out, valid_out, overrun_out.
module pwm_decoder #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int PWM_FREQ     = 20_480,
  parameter int BIT_W        = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             pwm_in,
  output logic [BIT_W-1:0] colour_out,
  output logic             valid_out,
  output logic             overrun_out
);

  import pwm_decoder_pkg::*;

  localparam int PERIOD_CYC  = pwm_period_cyc(SYS_CLK_FREQ, PWM_FREQ);
  localparam int TIMEOUT_CYC = 2 * PERIOD_CYC;
  localparam int CNT_W       = pwm_cnt_w(PERIOD_CYC);
  localparam int NUM_W       = CNT_W + BIT_W + 1;
  localparam logic [BIT_W-1:0] MAX = '1;

  logic q1, q2, q3, r_q;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  pwm_dec_state_t   state_q, state_d;
  logic             start, ovr, tmo;
  logic             busy, done;
  logic [NUM_W-1:0] num;
  logic [BIT_W-1:0] quotient;

  // Round to nearest: add half the period before dividing.
  assign num = NUM_W'(high_cnt) * NUM_W'(MAX)
             + NUM_W'(period_cnt >> 1);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ovr     = 1'b0;
    // A rise in the same cycle always beats the timeout.
    tmo = !r_q && (period_cnt == CNT_W'(TIMEOUT_CYC));
    unique case (state_q)
      IDLE: begin
        if (r_q) state_d = MEASURE;
      end
      MEASURE: begin
        if (r_q) begin
          if (busy) ovr = 1'b1;
          else      start = 1'b1;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      q1          <= 1'b0;
      q2          <= 1'b0;
      q3          <= 1'b0;
      r_q         <= 1'b0;
      state_q     <= IDLE;
      period_cnt  <= '0;
      high_cnt    <= '0;
      colour_out  <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      q1          <= pwm_in;
      q2          <= q1;
      q3          <= q2;
      r_q         <= q2 & ~q3;
      state_q     <= state_d;
      overrun_out <= ovr;
      valid_out   <= 1'b0;
      if (r_q || tmo) begin
        period_cnt <= CNT_W'(1);
        high_cnt   <= CNT_W'(1);
      end else begin
        period_cnt <= period_cnt + CNT_W'(1);
        if (q2) high_cnt <= high_cnt + CNT_W'(1);
      end
      // Timeout value takes priority over a quotient finishing now.
      if (tmo) begin
        colour_out <= q2 ? MAX : '0;
        valid_out  <= 1'b1;
      end else if (done) begin
        colour_out <= quotient;
        valid_out  <= 1'b1;
      end
    end
  end

  pwm_decoder_div #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W),
    .BIT_W(BIT_W)
  ) u_div (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .start   (start),
    .num     (num),
    .den     (period_cnt),
    .busy    (busy),
    .done    (done),
    .quotient(quotient)
  );

endmodule
